// File: rtl/bls12_381_fe2_mul_arbiter.sv
// Round-robin arbiter sharing one FE2 multiplier slot among NUM_REQ requesters; responses routed back by ctl tag.
// Latency: request handshake to o_mul_val is 1 cycle; response path is combinational (0 cycles).
// Backpressure: a held beat stays stable until i_mul_rdy; o_res_rdy follows the addressed requester, drains bad tags.
module bls12_381_fe2_mul_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DAT_BITS = 1524,
    parameter int RES_BITS = 762,
    parameter int CTL_BITS = 16,
    parameter int ARB_BIT  = 13
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req_val,
    output logic [NUM_REQ-1:0]           o_req_rdy,
    input  logic [NUM_REQ*DAT_BITS-1:0]  i_req_dat,
    input  logic [NUM_REQ*CTL_BITS-1:0]  i_req_ctl,
    output logic                         o_mul_val,
    input  logic                         i_mul_rdy,
    output logic [DAT_BITS-1:0]          o_mul_dat,
    output logic [CTL_BITS-1:0]          o_mul_ctl,
    input  logic                         i_res_val,
    output logic                         o_res_rdy,
    input  logic [RES_BITS-1:0]          i_res_dat,
    input  logic [CTL_BITS-1:0]          i_res_ctl,
    output logic [NUM_REQ-1:0]           o_rsp_val,
    input  logic [NUM_REQ-1:0]           i_rsp_rdy,
    output logic [RES_BITS-1:0]          o_rsp_dat,
    output logic [CTL_BITS-1:0]          o_rsp_ctl,
    output logic                         o_err
);
    localparam int IDB = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                mul_val_q, mul_val_d;
    logic [DAT_BITS-1:0] mul_dat_q, mul_dat_d;
    logic [CTL_BITS-1:0] mul_ctl_q, mul_ctl_d;
    logic [IDB-1:0]      ptr_q, ptr_d;
    logic                err_q, err_d;

    logic                free;
    logic                hi_vld, lo_vld, gnt_vld;
    logic [IDB-1:0]      hi_idx, lo_idx, gnt_idx;
    logic [DAT_BITS-1:0] sel_dat;
    logic [CTL_BITS-1:0] sel_ctl;
    logic [IDB-1:0]      res_id;
    logic                id_hit;

    // Output register may take a new beat when empty or when its beat leaves this cycle.
    assign free = ~mul_val_q | i_mul_rdy;

    // Round-robin search: lowest valid index at/above ptr wins, else lowest valid below ptr (wrap).
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req_val[k]) begin
                if (k >= int'(ptr_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = IDB'(k);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = IDB'(k);
                end
            end
        end
        gnt_vld = (hi_vld | lo_vld) & free & ~i_rst;
        gnt_idx = hi_vld ? hi_idx : lo_idx;
    end

    // One-hot ready to the winner and mux of its operands, with the index stamped into ctl.
    always_comb begin
        o_req_rdy = '0;
        sel_dat   = '0;
        sel_ctl   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDB'(k) == gnt_idx) begin
                o_req_rdy[k] = gnt_vld;
                sel_dat      = i_req_dat[k*DAT_BITS +: DAT_BITS];
                sel_ctl      = i_req_ctl[k*CTL_BITS +: CTL_BITS];
            end
        end
        sel_ctl[ARB_BIT +: IDB] = gnt_idx;
    end

    // Response routing by the returned tag; tags outside the requester range are drained and flagged.
    always_comb begin
        res_id    = i_res_ctl[ARB_BIT +: IDB];
        o_rsp_val = '0;
        o_res_rdy = 1'b1;
        id_hit    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(res_id) == k) begin
                id_hit       = 1'b1;
                o_rsp_val[k] = i_res_val;
                o_res_rdy    = i_rsp_rdy[k];
            end
        end
    end

    assign o_rsp_dat = i_res_dat;
    assign o_rsp_ctl = i_res_ctl;

    // Next state of the output stage, pointer and sticky error flag.
    always_comb begin
        mul_val_d = mul_val_q;
        mul_dat_d = mul_dat_q;
        mul_ctl_d = mul_ctl_q;
        ptr_d     = ptr_q;
        err_d     = err_q | (i_res_val & ~id_hit);
        if (gnt_vld) begin
            mul_val_d = 1'b1;
            mul_dat_d = sel_dat;
            mul_ctl_d = sel_ctl;
            ptr_d     = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDB'(1);
        end else if (i_mul_rdy) begin
            mul_val_d = 1'b0;
        end
    end

    // State registers; reset discards any held beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mul_val_q <= 1'b0;
            mul_dat_q <= '0;
            mul_ctl_q <= '0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            mul_val_q <= mul_val_d;
            mul_dat_q <= mul_dat_d;
            mul_ctl_q <= mul_ctl_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
        end
    end

    assign o_mul_val = mul_val_q;
    assign o_mul_dat = mul_dat_q;
    assign o_mul_ctl = mul_ctl_q;
    assign o_err     = err_q;

endmodule
